// File: rtl/mux_port_arbiter_pkg.sv
// mux_port_arbiter_pkg: shared state encoding, requester indices and round-robin picker
package mux_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LSU   = 1;
    localparam int REQ_DEBUG = 2;
    localparam int REQ_DMA   = 3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scans ptr, ptr+1, ptr+2, ptr+3 (mod 4); the closest set request wins.
    function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] k;
        p = '0;
        for (int i = 3; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_port_arbiter_mux.sv
// multiplexer_4_to_1: plain 4:1 data multiplexer
module multiplexer_4_to_1 #(
    parameter int N_BITS = 32
) (
    input  logic [1:0]        selector_i,
    input  logic [N_BITS-1:0] data_0_i,
    input  logic [N_BITS-1:0] data_1_i,
    input  logic [N_BITS-1:0] data_2_i,
    input  logic [N_BITS-1:0] data_3_i,
    output logic [N_BITS-1:0] data_o
);

    // Route the selected channel; always driven, so no X leaks when idle.
    always_comb
        data_o = selector_i[1] ? (selector_i[0] ? data_3_i : data_2_i)
                               : (selector_i[0] ? data_1_i : data_0_i);

endmodule

// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter: round-robin burst arbiter for one shared datapath port
module mux_port_arbiter
    import mux_port_arbiter_pkg::*;
#(
    parameter int N_BITS    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req_i,
    input  logic [N_BITS-1:0] data_0_i,
    input  logic [N_BITS-1:0] data_1_i,
    input  logic [N_BITS-1:0] data_2_i,
    input  logic [N_BITS-1:0] data_3_i,
    input  logic              ready_i,
    output logic [3:0]        grant_o,
    output logic [1:0]        sel_o,
    output logic              valid_o,
    output logic [N_BITS-1:0] data_o,
    output logic              beat_o
);

    localparam int            CW   = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic          release_now;
    logic [1:0]    scan_ptr;
    pick_t         pick;

    multiplexer_4_to_1 #(.N_BITS(N_BITS)) u_mux (
        .selector_i (sel_o),
        .data_0_i   (data_0_i),
        .data_1_i   (data_1_i),
        .data_2_i   (data_2_i),
        .data_3_i   (data_3_i),
        .data_o     (data_o)
    );

    // Handshake, release decision and next-owner pick; scanning from owner+1 leaves the
    // releasing owner last, so it is re-granted only when it is the sole requester.
    always_comb begin
        valid_o     = !reset && state == BUSY && req_i[sel_o];
        beat_o      = valid_o && ready_i;
        release_now = state == BUSY && ((beat_o && cnt == LAST) || !req_i[sel_o]);
        scan_ptr    = release_now ? sel_o + 2'd1 : ptr;
        pick        = rr_pick(req_i, scan_ptr);
    end

    // Ownership FSM: grant from idle or hand over on release, otherwise count beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_o <= '0;
            sel_o   <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else if (state == IDLE || release_now) begin
            if (release_now) begin
                ptr <= sel_o + 2'd1;
                cnt <= '0;
            end
            state   <= pick.found ? BUSY : IDLE;
            grant_o <= pick.found ? 4'b0001 << pick.idx : 4'b0000;
            if (pick.found)
                sel_o <= pick.idx;
        end else if (beat_o) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// tb_mux_port_arbiter: directed tests plus per-cycle model compare for BURST_LEN 4 and 1
module tb_mux_port_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic         ready;
    logic [N-1:0] d [4];

    logic [3:0]   grant [2];
    logic [1:0]   sel   [2];
    logic         valid [2];
    logic         beat  [2];
    logic [N-1:0] dout  [2];

    int  errors  = 0;
    int  checks  = 0;
    bit  started = 0;
    int  nb;

    int  blen  [2] = '{4, 1};
    int  m_busy[2] = '{0, 0};
    int  m_sel [2] = '{0, 0};
    int  m_ptr [2] = '{0, 0};
    int  m_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    mux_port_arbiter #(.N_BITS(N), .BURST_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .req_i(req),
        .data_0_i(d[0]), .data_1_i(d[1]), .data_2_i(d[2]), .data_3_i(d[3]),
        .ready_i(ready), .grant_o(grant[0]), .sel_o(sel[0]), .valid_o(valid[0]),
        .data_o(dout[0]), .beat_o(beat[0])
    );

    mux_port_arbiter #(.N_BITS(N), .BURST_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .req_i(req),
        .data_0_i(d[0]), .data_1_i(d[1]), .data_2_i(d[2]), .data_3_i(d[3]),
        .ready_i(ready), .grant_o(grant[1]), .sel_o(sel[1]), .valid_o(valid[1]),
        .data_o(dout[1]), .beat_o(beat[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: owner, beats taken in this burst and rotation pointer, advanced at each edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_busy[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
            end else begin
                if (m_busy[m] != 0) begin
                    if (!req[m_sel[m]]) begin
                        m_busy[m] = 0; m_ptr[m] = (m_sel[m] + 1) % 4; m_cnt[m] = 0;
                    end else if (ready) begin
                        m_cnt[m]++;
                        if (m_cnt[m] == blen[m]) begin
                            m_busy[m] = 0; m_ptr[m] = (m_sel[m] + 1) % 4; m_cnt[m] = 0;
                        end
                    end
                end
                if (m_busy[m] == 0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_busy[m] == 0 && req[(m_ptr[m] + i) % 4]) begin
                            m_busy[m] = 1;
                            m_sel[m]  = (m_ptr[m] + i) % 4;
                        end
                    end
                end
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                bit v;
                v = !reset && m_busy[m] != 0 && req[m_sel[m]];
                chk($sformatf("grant[%0d]", m), 64'(grant[m]), m_busy[m] != 0 ? 64'(1) << m_sel[m] : 64'd0);
                chk($sformatf("sel[%0d]", m), 64'(sel[m]), 64'(m_sel[m]));
                chk($sformatf("valid[%0d]", m), 64'(valid[m]), 64'(v));
                chk($sformatf("beat[%0d]", m), 64'(beat[m]), 64'(v && ready));
                if (v)
                    chk($sformatf("data[%0d]", m), 64'(dout[m]), 64'(d[m_sel[m]]));
            end
        end
    end

    initial begin
        reset = 1'b1; req = 4'hF; ready = 1'b1;
        d[0] = 32'h1111_0000; d[1] = 32'h2222_0001; d[2] = 32'h3333_0002; d[3] = 32'h4444_0003;
        // reset held two cycles with all requests up
        @(posedge clk); started = 1; #1;
        tick();
        chk("rst_grant_a", 64'(grant[0]), 64'd0);
        chk("rst_sel_a",   64'(sel[0]),   64'd0);
        chk("rst_valid_a", 64'(valid[0]), 64'd0);
        chk("rst_beat_a",  64'(beat[0]),  64'd0);
        chk("rst_grant_b", 64'(grant[1]), 64'd0);
        // single requester 2, burst of four then regrant without a bubble
        reset = 1'b0; req = 4'b0100;
        nb = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) chk("t2_grant", 64'(grant[0]), 64'b0100);
            nb += int'(beat[0]);
        end
        chk("t2_beats", 64'(nb), 64'd4);
        tick();
        chk("t2_nobubble", 64'(grant[0]), 64'b0100);
        chk("t2_beat5",    64'(beat[0]),  64'd1);
        chk("t2_data",     64'(dout[0]),  64'h3333_0002);
        chk("t2_model_ptr", 64'(m_ptr[0]), 64'd3);
        req = 4'b0000;
        tick(2);
        // all requesting with BURST_LEN=1: strict rotation
        reset = 1'b1; tick(); reset = 1'b0; req = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t3_sel%0d", c), 64'(sel[1]), 64'(c % 4));
            chk($sformatf("t3_beat%0d", c), 64'(beat[1]), 64'd1);
        end
        // owner 1 stalled three cycles mid-burst, still four beats total
        reset = 1'b1; tick(); reset = 1'b0; req = 4'b0010; ready = 1'b1;
        nb = 0;
        tick(); nb += int'(beat[0]);
        tick(); nb += int'(beat[0]);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) begin ready = 1'b0; req = 4'b0011; end
            #1;
            chk("t4_stall_beat",  64'(beat[0]),  64'd0);
            chk("t4_stall_sel",   64'(sel[0]),   64'd1);
            chk("t4_stall_valid", 64'(valid[0]), 64'd1);
        end
        tick(); ready = 1'b1; #1; nb += int'(beat[0]);
        tick(); nb += int'(beat[0]);
        chk("t4_beats", 64'(nb), 64'd4);
        tick();
        chk("t4_next_sel",   64'(sel[0]),   64'd0);
        chk("t4_next_grant", 64'(grant[0]), 64'b0001);
        // owner 3 drops after two beats, requester 0 takes over
        reset = 1'b1; tick(); reset = 1'b0; req = 4'b1000;
        tick(); tick();
        tick(); req = 4'b0001; #1;
        chk("t5_drop_valid", 64'(valid[0]), 64'd0);
        chk("t5_drop_beat",  64'(beat[0]),  64'd0);
        tick();
        chk("t5_grant", 64'(grant[0]), 64'b0001);
        chk("t5_sel",   64'(sel[0]),   64'd0);
        chk("t5_model_ptr", 64'(m_ptr[0]), 64'd0);
        // reset during beat 2 of owner 2
        reset = 1'b1; tick(); reset = 1'b0; req = 4'b0100;
        tick();
        tick(); reset = 1'b1; #1;
        chk("t6_rst_beat", 64'(beat[0]), 64'd0);
        tick();
        chk("t6_grant", 64'(grant[0]), 64'd0);
        chk("t6_sel",   64'(sel[0]),   64'd0);
        chk("t6_valid", 64'(valid[0]), 64'd0);
        reset = 1'b0; req = 4'b1010; #1;
        chk("t6_idle_valid", 64'(valid[0]), 64'd0);
        tick();
        chk("t6_ptr_sel",   64'(sel[0]),   64'd1);
        chk("t6_ptr_grant", 64'(grant[0]), 64'b0010);
        req = 4'b0000;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
